ps2_host_tx: RTL

- Host-to-device PS/2 transmitter. Sends one command byte (for example 0xED set-LEDs, 0xFF reset, 0xF4 enable) to the keyboard over the shared PS2_CLK/PS2_DATA lines.
- Sits beside KeyboardDecoder, the receive path, in the game top level.
- Drives the open-drain lines through active-high pull-low enables. The top level ties `PS2_CLK = ps2_clk_oe ? 1'b0 : 1'bz`, and likewise for PS2_DATA.
- While `busy` is high, the top level ignores the decoder's key_valid.

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_sync_edge.sv | 30 +++
 rtl/ps2_host_tx.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    WAIT_IDLE,
    DONE,
    ERR
  } state_e;

  localparam int         FRAME_BITS = 11;
  localparam logic [3:0] PARITY_BIT = 4'd8;
  localparam logic [3:0] STOP_BIT   = 4'd9;
  localparam logic [3:0] ACK_BIT    = 4'd10;

  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a raw PS/2 pin with a registered falling-edge flag.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic sync_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q, fall_q;

  // Idle PS/2 lines float high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      meta_q <= din_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      fall_q <= prev_q & ~sync_q;
    end
  end

  assign sync_o = sync_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the clock, requests to send,
// shifts out an 11-bit frame on device clock falls and checks the device ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int SETUP_CYCLES   = 100,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST     = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       data_q, data_d;
  logic             parity_q, parity_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic clk_s, clk_fall, data_s, data_fall_unused;
  logic accept;

  ps2_sync_edge u_clk_sync (
    .clk    (clk),
    .rst    (rst),
    .din_i  (ps2_clk_in),
    .sync_o (clk_s),
    .fall_o (clk_fall)
  );

  ps2_sync_edge u_data_sync (
    .clk    (clk),
    .rst    (rst),
    .din_i  (ps2_data_in),
    .sync_o (data_s),
    .fall_o (data_fall_unused)
  );

  assign tx_ready = (state_q == IDLE);
  assign busy     = ~tx_ready;
  assign accept   = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tmo_q     <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      parity_q  <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    parity_d  = parity_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = INHIBIT;
          cnt_d    = '0;
          data_d   = tx_data;
          parity_d = ~^tx_data;
        end
      end
      INHIBIT: begin
        if (cnt_q == INHIBIT_LAST) begin
          state_d = REQ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REQ: begin
        if (cnt_q == SETUP_LAST) begin
          state_d   = SEND;
          cnt_d     = '0;
          bit_cnt_d = '0;
          tmo_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SEND: begin
        tmo_d = tmo_q + TMO_W'(1);
        // Timeout wins over a fall landing in the same cycle.
        if (tmo_q == TMO_LAST) begin
          state_d = ERR;
        end else if (clk_fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == ACK_BIT) begin
            state_d = data_s ? ERR : WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (tmo_q == TMO_LAST) begin
          state_d = ERR;
        end else if (clk_s && data_s) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they track state_q exactly.
  always_comb begin
    clk_oe_d  = (state_d == INHIBIT) || (state_d == REQ);
    done_d    = (state_d == DONE);
    err_d     = (state_d == ERR);
    data_oe_d = 1'b0;
    case (state_d)
      REQ: data_oe_d = 1'b1;
      SEND: begin
        if (state_q == REQ) begin
          data_oe_d = 1'b1;
        end else if (clk_fall) begin
          if (bit_cnt_q < PARITY_BIT) begin
            data_oe_d = ~data_q[bit_cnt_q[2:0]];
          end else if (bit_cnt_q == PARITY_BIT) begin
            data_oe_d = ~parity_q;
          end else begin
            data_oe_d = 1'b0;
          end
        end else begin
          data_oe_d = data_oe_q;
        end
      end
      default: data_oe_d = 1'b0;
    endcase
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;

endmodule
